// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//
// Purpose:
//   Front end for a two-denomination coin mechanism. Each raw sensor level is
//   synchronized, debounced and turned into a single one-cycle credit pulse
//   (coin5 / coin10) or a one-cycle reject pulse. A sensor that stays blocked
//   too long after a decision is treated as a jam, which sticks until reset.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   sense5_raw   in   raw 5-unit sensor level (asynchronous to clk)
//   sense10_raw  in   raw 10-unit sensor level (asynchronous to clk)
//   accept_en    in   downstream can take credit; sampled only on decision edge
//   coin5        out  one-cycle validated 5-unit pulse
//   coin10       out  one-cycle validated 10-unit pulse
//   reject       out  one-cycle coin-returned pulse
//   jam          out  sticky jam flag
//   busy         out  high whenever the FSM is not IDLE
//
// Handshake: there is no valid/ready pair here. accept_en acts as a level
// "ready" that is looked at only on the edge where the debounce count
// completes; a credit pulse is the "valid" and lasts exactly one cycle with
// no back-pressure, so the consumer must take it in that cycle.
// -----------------------------------------------------------------------------
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sense5_raw,
  input  logic sense10_raw,
  input  logic accept_en,
  output logic coin5,
  output logic coin10,
  output logic reject,
  output logic jam,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2,
    JAM          = 2'd3
  } state_t;

  // Count value held in DEBOUNCE when the next high sample is the last one.
  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] JAM_LIM  = 16'(JAM_CYCLES);

  // Two-flop synchronizers, bit 1 is the synchronized level.
  logic [1:0]  sync5_q, sync10_q;
  logic        s5, s10;

  state_t      state_q, state_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [15:0] rel_cnt_q, rel_cnt_d;
  logic        den10_q, den10_d;   // recorded denomination: 1 = 10-unit
  logic        coin5_q, coin5_d;
  logic        coin10_q, coin10_d;
  logic        reject_q, reject_d;
  logic        jam_q, jam_d;
  logic        busy_q, busy_d;

  // Helpers for DEBOUNCE: the sensor we are tracking and the other one.
  logic        rec_s, oth_s;
  logic [7:0]  deb_inc;
  logic [15:0] rel_inc;

  assign s5  = sync5_q[1];
  assign s10 = sync10_q[1];

  assign rec_s = den10_q ? s10 : s5;
  assign oth_s = den10_q ? s5  : s10;

  // Saturating increments; the counters can never wrap.
  assign deb_inc = (deb_cnt_q == 8'hFF)    ? deb_cnt_q : deb_cnt_q + 8'd1;
  assign rel_inc = (rel_cnt_q == 16'hFFFF) ? rel_cnt_q : rel_cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    den10_d   = den10_q;
    coin5_d   = 1'b0;
    coin10_d  = 1'b0;
    reject_d  = 1'b0;
    jam_d     = jam_q;

    case (state_q)
      IDLE: begin
        if (s5 && s10) begin
          // Both sensors at once is ambiguous: return the coin.
          reject_d  = 1'b1;
          rel_cnt_d = 16'd0;
          state_d   = WAIT_RELEASE;
        end else if (s5 || s10) begin
          den10_d   = s10;
          deb_cnt_d = 8'd1;
          state_d   = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (oth_s) begin
          reject_d  = 1'b1;
          rel_cnt_d = 16'd0;
          state_d   = WAIT_RELEASE;
        end else if (rec_s) begin
          if (deb_cnt_q >= DEB_LAST) begin
            // Decision edge: this is the only place accept_en is looked at.
            if (accept_en) begin
              coin5_d  = ~den10_q;
              coin10_d = den10_q;
            end else begin
              reject_d = 1'b1;
            end
            rel_cnt_d = 16'd0;
            state_d   = WAIT_RELEASE;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end else begin
          // Dropped before validation: glitch, no output.
          deb_cnt_d = 8'd0;
          state_d   = IDLE;
        end
      end

      WAIT_RELEASE: begin
        if (!s5 && !s10) begin
          rel_cnt_d = 16'd0;
          state_d   = IDLE;
        end else begin
          rel_cnt_d = rel_inc;
          if (rel_inc >= JAM_LIM) begin
            jam_d   = 1'b1;
            state_d = JAM;
          end
        end
      end

      JAM: begin
        // Only reset leaves this state.
        jam_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync5_q   <= 2'b00;
      sync10_q  <= 2'b00;
      state_q   <= IDLE;
      deb_cnt_q <= 8'd0;
      rel_cnt_q <= 16'd0;
      den10_q   <= 1'b0;
      coin5_q   <= 1'b0;
      coin10_q  <= 1'b0;
      reject_q  <= 1'b0;
      jam_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync5_q   <= {sync5_q[0], sense5_raw};
      sync10_q  <= {sync10_q[0], sense10_raw};
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      den10_q   <= den10_d;
      coin5_q   <= coin5_d;
      coin10_q  <= coin10_d;
      reject_q  <= reject_d;
      jam_q     <= jam_d;
      busy_q    <= busy_d;
    end
  end

  assign coin5  = coin5_q;
  assign coin10 = coin10_q;
  assign reject = reject_q;
  assign jam    = jam_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//
// Bench for coin_acceptor with default parameters (D=4, JAM_CYCLES=64).
// Every pulse the bench expects is pushed as {cycle, code} when the stimulus
// is driven; the monitor pops and compares whenever a pulse appears.
// Codes: 1 = coin5, 2 = coin10, 3 = reject.
// Cycle numbering: cyc holds the number of rising edges seen; an event started
// right after edge m has its first sampled raw edge at k = m+1.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int J = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic sense5_raw, sense10_raw, accept_en;
  logic coin5, coin10, reject, jam, busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
    .clk        (clk),
    .reset      (reset),
    .sense5_raw (sense5_raw),
    .sense10_raw(sense10_raw),
    .accept_en  (accept_en),
    .coin5      (coin5),
    .coin10     (coin10),
    .reject     (reject),
    .jam        (jam),
    .busy       (busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int at_cyc, input logic [1:0] code);
    logic [31:0] c;
    c = at_cyc;
    exp_q.push_back({c, code});
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    logic [1:0]  code;
    logic [31:0] c;
    logic [33:0] e;
    if (coin5 || coin10 || reject) begin
      check("exclusive", 64'(int'(coin5) + int'(coin10) + int'(reject)), 64'd1);
      code = coin5 ? 2'd1 : (coin10 ? 2'd2 : 2'd3);
      c    = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'({c, code}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle_code", 64'({c, code}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_idle();
    sense5_raw  = 1'b0;
    sense10_raw = 1'b0;
    accept_en   = 1'b0;
    repeat (8) step();
    check("idle_after", 64'({busy, jam}), 64'd0);
  endtask

  // acc: 0 = accept_en low, 1 = high, 2 = high only on decision edge,
  // 3 = high everywhere except the decision edge.
  task automatic drive_event(input int n5, input int n10, input int acc,
                             input int code, input int lat);
    int m, len;
    m = cyc;
    if (code != 0) expect_pulse(m + lat, 2'(code));
    len = (n5 > n10) ? n5 : n10;
    if (len < 6) len = 6;
    for (int i = 0; i < len; i++) begin
      sense5_raw  = (i < n5);
      sense10_raw = (i < n10);
      case (acc)
        1:       accept_en = 1'b1;
        2:       accept_en = (i == 5);
        3:       accept_en = (i != 5);
        default: accept_en = 1'b0;
      endcase
      step();
    end
    settle_idle();
  endtask

  function automatic int model_code(input int n, input int den10, input int acc);
    if (n < D) return 0;
    if (acc == 0) return 3;
    return den10 ? 2 : 1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int n5;
    int n10;
    int acc;
    int code;
    int lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int m, n, den, acc;

    vecs[0]  = '{7, 0, 1, 1, 6};   // basic coin5
    vecs[1]  = '{0, 2, 1, 0, 0};   // 10-unit glitch, filtered
    vecs[2]  = '{7, 7, 1, 3, 3};   // simultaneous rise -> reject
    vecs[3]  = '{0, 8, 0, 3, 6};   // not accepted -> reject
    vecs[4]  = '{0, 6, 1, 2, 6};   // basic coin10
    vecs[5]  = '{4, 0, 1, 1, 6};   // exactly D samples
    vecs[6]  = '{3, 0, 1, 0, 0};   // D-1 samples, filtered
    vecs[7]  = '{1, 0, 1, 0, 0};   // single-sample glitch
    vecs[8]  = '{5, 5, 0, 3, 3};   // simultaneous with accept low
    vecs[9]  = '{20, 0, 1, 1, 6};  // long hold, below jam limit
    vecs[10] = '{0, 8, 2, 2, 6};   // accept_en only on decision edge
    vecs[11] = '{8, 0, 3, 3, 6};   // accept_en low only on decision edge
    vecs[12] = '{0, 3, 1, 0, 0};   // 10-unit D-1 samples

    reset       = 1'b1;
    sense5_raw  = 1'b0;
    sense10_raw = 1'b0;
    accept_en   = 1'b0;
    repeat (3) step();
    check("reset_outputs", 64'({coin5, coin10, reject, jam, busy}), 64'd0);
    reset = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 13; i++)
      drive_event(vecs[i].n5, vecs[i].n10, vecs[i].acc, vecs[i].code, vecs[i].lat);

    // Randomised single-sensor events checked against a small model.
    for (int i = 0; i < 6; i++) begin
      n   = $urandom_range(1, 10);
      den = $urandom_range(0, 1);
      acc = $urandom_range(0, 1);
      drive_event(den ? 0 : n, den ? n : 0, acc, model_code(n, den, acc), 6);
    end

    // Other sensor rises two samples into DEBOUNCE -> reject.
    m = cyc;
    expect_pulse(m + 5, 2'd3);
    accept_en  = 1'b1;
    sense5_raw = 1'b1;
    repeat (2) step();
    sense10_raw = 1'b1;
    repeat (6) step();
    settle_idle();

    // Reset mid-debounce: pending pulse dropped, still-high sensor restarts.
    m = cyc;
    expect_pulse(m + 10, 2'd1);
    accept_en  = 1'b1;
    sense5_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      reset = (i == 3);
      step();
    end
    reset = 1'b0;
    settle_idle();

    // Jam: sensor blocked for 100 edges after a coin5.
    m = cyc;
    expect_pulse(m + 6, 2'd1);
    accept_en  = 1'b1;
    sense5_raw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cyc == m + 69) check("jam_before_limit", 64'(jam), 64'd0);
      if (cyc == m + 70) check("jam_at_limit", 64'(jam), 64'd1);
    end
    sense5_raw = 1'b0;
    repeat (4) step();
    // Coins while jammed are ignored.
    sense10_raw = 1'b1;
    repeat (8) step();
    sense10_raw = 1'b0;
    repeat (6) step();
    check("jam_sticky", 64'({jam, busy}), 64'b11);
    // Reset is the only way out.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("jam_cleared", 64'({jam, busy}), 64'd0);
    step();
    drive_event(7, 0, 1, 1, 6);

    repeat (10) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
